coin_acceptor_frontend: RTL and testbench

// Upstream stage of the vending FSM. Conditions raw mechanical coin-sensor lines
// and queues validated coins. Delivers them as clean, single-cycle, mutually

---
 rtl/coin_acceptor_if.sv | 21 ++
 rtl/coin_acceptor_frontend.sv | 91 +++++++++
 tb/tb_coin_acceptor_frontend.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin sensor / consumer bus for coin_acceptor_frontend.
//   raw_coin5, raw_coin10 : raw asynchronous sensor lines (may bounce)
//   coin_ready            : consumer can take a coin this cycle
//   coin5, coin10         : single-cycle delivered-coin pulses
//   coin_return, jam      : single-cycle reject / jam pulses
//   pending, drop_count   : FIFO occupancy, saturating reject count
interface coin_acceptor_if #(parameter int FIFO_DEPTH = 4);
   logic                          raw_coin5;
   logic                          raw_coin10;
   logic                          coin_ready;
   logic                          coin5;
   logic                          coin10;
   logic                          coin_return;
   logic                          jam;
   logic [$clog2(FIFO_DEPTH):0]   pending;
   logic [7:0]                    drop_count;
   modport master (output raw_coin5, raw_coin10, coin_ready,
                   input  coin5, coin10, coin_return, jam, pending, drop_count);
   modport slave  (input  raw_coin5, raw_coin10, coin_ready,
                   output coin5, coin10, coin_return, jam, pending, drop_count);
endinterface

// File: rtl/coin_acceptor_frontend.sv
// coin_acceptor_frontend: sync, debounce, edge-detect and queue coin sensor events,
// delivering paced single-cycle coin5/coin10 pulses; jams and overflows are rejected.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : coin_acceptor_if slave (raw lines + coin_ready in; pulses, pending, drop_count out)
module coin_acceptor_frontend #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 4,
   parameter int MIN_GAP         = 1
) (
   input logic             clk,
   input logic             rst,
   coin_acceptor_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(MIN_GAP + 2);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   logic [1:0]            r_s1, r_s2, r_stable, r_stable_q;
   logic [CW-1:0]         r_cnt [2];
   logic [FIFO_DEPTH-1:0] r_mem;
   logic [AW:0]           r_wr, r_rd;
   logic [GW-1:0]         r_gap;
   logic                  r_coin5, r_coin10, r_ret, r_jam;
   logic [7:0]            r_drop;
   logic [1:0]            w_ev;
   logic [AW:0]           w_pending;
   logic                  w_pop, w_jam, w_single, w_push, w_drop, w_head;
   // bit 0 = 5-unit channel, bit 1 = 10-unit channel
   assign w_ev      = r_stable & ~r_stable_q;
   assign w_pending = r_wr - r_rd;
   assign w_pop     = (w_pending != '0) & bus.coin_ready & (r_gap == '0);
   assign w_jam     = &w_ev;
   assign w_single  = ^w_ev;
   // a pop on the same edge frees the slot, so a full FIFO still accepts
   assign w_push    = w_single & ((w_pending != FULL) | w_pop);
   assign w_drop    = w_jam | (w_single & ~w_push);
   assign w_head    = r_mem[r_rd[AW-1:0]];
   // stable levels start high so a line held high through reset never counts as a coin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_stable   <= '1;
         r_stable_q <= '1;
         r_cnt      <= '{default: '0};
      end else begin
         r_s1       <= {bus.raw_coin10, bus.raw_coin5};
         r_s2       <= r_s1;
         r_stable_q <= r_stable;
         for (int c = 0; c < 2; c++)
            if (r_s2[c] != r_stable[c]) begin
               if (r_cnt[c] == CW'(DEBOUNCE_CYCLES)) begin
                  r_stable[c] <= r_s2[c];
                  r_cnt[c]    <= '0;
               end else
                  r_cnt[c] <= r_cnt[c] + 1'b1;
            end else
               r_cnt[c] <= '0;
      end
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr[AW-1:0]] <= w_ev[1];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_gap    <= '0;
         r_coin5  <= 1'b0;
         r_coin10 <= 1'b0;
         r_ret    <= 1'b0;
         r_jam    <= 1'b0;
         r_drop   <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_gap    <= w_pop ? GW'(MIN_GAP) : (r_gap != '0 ? r_gap - 1'b1 : r_gap);
         r_coin5  <= w_pop & ~w_head;
         r_coin10 <= w_pop & w_head;
         r_ret    <= w_drop;
         r_jam    <= w_jam;
         if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
      end
   end
   assign bus.coin5       = r_coin5;
   assign bus.coin10      = r_coin10;
   assign bus.coin_return = r_ret;
   assign bus.jam         = r_jam;
   assign bus.pending     = w_pending;
   assign bus.drop_count  = r_drop;
endmodule

// File: tb/tb_coin_acceptor_frontend.sv
// tb_coin_acceptor_frontend: vector table, corner sequences and a random run against a queue model.
module tb_coin_acceptor_frontend;
   localparam int D = 16, DEPTH = 4, GAP = 1, N = 3000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();
   coin_acceptor_frontend #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   int checks = 0, failures = 0;
   int n5 = 0, n10 = 0, nret = 0, njam = 0, nboth = 0;
   always @(negedge clk) begin
      n5    += int'(bus.coin5);
      n10   += int'(bus.coin10);
      nret  += int'(bus.coin_return);
      njam  += int'(bus.jam);
      nboth += int'(bus.coin5 & bus.coin10);
   end
   typedef struct {
      bit r5; bit r10; int hi; int lo; int hi2;
      int e5; int e10; int eret; int ejam; int edrop;
   } vec_t;
   vec_t tbl [7];
   bit r5a [N];
   bit r10a [N];
   bit e5a [N];
   bit e10a [N];
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic ins(bit c10);
      if (c10) bus.raw_coin10 = 1'b1; else bus.raw_coin5 = 1'b1;
      step(25);
      bus.raw_coin5  = 1'b0;
      bus.raw_coin10 = 1'b0;
      step(25);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int s5, s10, sret, sjam, first, cnt, p19, p20, t, h, thr, last_pop, mdrop;
      int thr_tab [3];
      bit q [$];
      logic [14:0] e, a;
      tbl[0] = '{1'b1, 1'b0, 40, 0, 0,  1, 0, 0, 0, 0};
      tbl[1] = '{1'b0, 1'b1, 40, 0, 0,  0, 1, 0, 0, 0};
      tbl[2] = '{1'b0, 1'b1, 10, 3, 10, 0, 0, 0, 0, 0};
      tbl[3] = '{1'b1, 1'b0, 15, 0, 0,  0, 0, 0, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 18, 0, 0,  1, 0, 0, 0, 0};
      tbl[5] = '{1'b1, 1'b1, 30, 0, 0,  0, 0, 1, 1, 1};
      tbl[6] = '{1'b0, 1'b1, 18, 0, 0,  0, 1, 0, 0, 1};
      thr_tab = '{5, 40, 95};
      bus.raw_coin5 = 1'b0;
      bus.raw_coin10 = 1'b0;
      bus.coin_ready = 1'b1;
      step(3);
      chk("rst_coin5", int'(bus.coin5), 0);
      chk("rst_coin10", int'(bus.coin10), 0);
      chk("rst_return", int'(bus.coin_return), 0);
      chk("rst_jam", int'(bus.jam), 0);
      chk("rst_pending", int'(bus.pending), 0);
      chk("rst_drop", int'(bus.drop_count), 0);
      rst = 1'b0;
      step(25);
      first = -1; cnt = 0; p19 = -1; p20 = -1;
      bus.raw_coin5 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step(1);
         if (bus.coin5) begin
            cnt++;
            if (first < 0) first = k;
         end
         if (k == 19) p19 = int'(bus.pending);
         if (k == 20) p20 = int'(bus.pending);
      end
      bus.raw_coin5 = 1'b0;
      step(30);
      chk("lat_edge", first, D + 4);
      chk("lat_count", cnt, 1);
      chk("lat_pending_push", p19, 1);
      chk("lat_pending_pop", p20, 0);
      for (int i = 0; i < 7; i++) begin
         s5 = n5; s10 = n10; sret = nret; sjam = njam;
         bus.raw_coin5 = tbl[i].r5;
         bus.raw_coin10 = tbl[i].r10;
         step(tbl[i].hi);
         bus.raw_coin5 = 1'b0;
         bus.raw_coin10 = 1'b0;
         step(tbl[i].lo);
         if (tbl[i].hi2 > 0) begin
            bus.raw_coin5 = tbl[i].r5;
            bus.raw_coin10 = tbl[i].r10;
            step(tbl[i].hi2);
            bus.raw_coin5 = 1'b0;
            bus.raw_coin10 = 1'b0;
         end
         step(45);
         chk($sformatf("vec%0d_coin5", i), n5 - s5, tbl[i].e5);
         chk($sformatf("vec%0d_coin10", i), n10 - s10, tbl[i].e10);
         chk($sformatf("vec%0d_return", i), nret - sret, tbl[i].eret);
         chk($sformatf("vec%0d_jam", i), njam - sjam, tbl[i].ejam);
         chk($sformatf("vec%0d_drop", i), int'(bus.drop_count), tbl[i].edrop);
      end
      bus.coin_ready = 1'b0;
      ins(0); ins(1); ins(0); ins(1);
      chk("fill_pending", int'(bus.pending), 4);
      sret = nret;
      ins(0);
      chk("overflow_return", nret - sret, 1);
      chk("overflow_drop", int'(bus.drop_count), 2);
      chk("overflow_pending", int'(bus.pending), 4);
      bus.coin_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk($sformatf("drain%0d", k), int'({bus.coin10, bus.coin5}),
             (k % 2 == 0 && k < 8) ? ((k / 2) % 2 == 1 ? 2 : 1) : 0);
      end
      chk("drain_pending", int'(bus.pending), 0);
      bus.coin_ready = 1'b0;
      ins(0); ins(1); ins(0); ins(1);
      sret = nret;
      bus.raw_coin5 = 1'b1;
      step(19);
      chk("full_pre_pending", int'(bus.pending), 4);
      s5 = n5; s10 = n10;
      bus.coin_ready = 1'b1;
      step(1);
      chk("pushpop_pending", int'(bus.pending), 4);
      chk("pushpop_return", int'(bus.coin_return), 0);
      chk("pushpop_coin5", int'(bus.coin5), 1);
      step(6);
      bus.raw_coin5 = 1'b0;
      step(30);
      chk("pushpop_total5", n5 - s5, 3);
      chk("pushpop_total10", n10 - s10, 2);
      chk("pushpop_noreturn", nret - sret, 0);
      chk("pushpop_drop", int'(bus.drop_count), 2);
      bus.coin_ready = 1'b0;
      ins(0); ins(1); ins(0);
      chk("pre_rst_pending", int'(bus.pending), 3);
      bus.raw_coin5 = 1'b1;
      bus.coin_ready = 1'b1;
      step(1);
      chk("pre_rst_pulse", int'(bus.coin5), 1);
      rst = 1'b1;
      #1;
      chk("midrst_coin5", int'(bus.coin5), 0);
      chk("midrst_pending", int'(bus.pending), 0);
      chk("midrst_drop", int'(bus.drop_count), 0);
      chk("midrst_return", int'(bus.coin_return), 0);
      step(2);
      rst = 1'b0;
      s5 = n5; s10 = n10; sret = nret;
      step(40);
      chk("postrst_coin5", n5 - s5, 0);
      chk("postrst_coin10", n10 - s10, 0);
      chk("postrst_return", nret - sret, 0);
      chk("postrst_pending", int'(bus.pending), 0);
      bus.raw_coin5 = 1'b0;
      step(30);
      t = 0;
      while (t < N - 80) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         h = kind <= 2 ? int'($urandom_range(20, 30)) : int'($urandom_range(1, 12));
         for (int i = 0; i < h; i++) begin
            r5a[t + i]  = (kind == 0 || kind == 2 || kind == 3);
            r10a[t + i] = (kind == 1 || kind == 2 || kind == 4);
         end
         if (kind <= 2) begin
            e5a[t + D + 3]  = (kind != 1);
            e10a[t + D + 3] = (kind != 0);
         end
         t += h + int'($urandom_range(22, 30));
      end
      last_pop = -100; mdrop = 0; thr = 50;
      for (int c = 0; c < N; c++) begin
         bit pop, x5, x10, ret, jm;
         int sz;
         if (c % 200 == 0) thr = thr_tab[$urandom_range(0, 2)];
         bus.raw_coin5 = r5a[c];
         bus.raw_coin10 = r10a[c];
         bus.coin_ready = int'($urandom_range(0, 99)) < thr;
         sz = q.size();
         pop = sz > 0 && bus.coin_ready && (c - last_pop > GAP);
         x5 = pop && !q[0];
         x10 = pop && q[0];
         if (pop) begin
            void'(q.pop_front());
            last_pop = c;
         end
         jm = e5a[c] && e10a[c];
         ret = jm;
         if (e5a[c] != e10a[c]) begin
            if (sz < DEPTH || pop) q.push_back(e10a[c]);
            else ret = 1'b1;
         end
         if (ret && mdrop < 255) mdrop++;
         e = {x5, x10, ret, jm, 3'(q.size()), 8'(mdrop)};
         step(1);
         a = {bus.coin5, bus.coin10, bus.coin_return, bus.jam, bus.pending, bus.drop_count};
         chk($sformatf("rand_c%0d", c), int'(a), int'(e));
      end
      chk("never_both", nboth, 0);
      bus.raw_coin5 = 1'b0;
      bus.raw_coin10 = 1'b0;
      step(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
